// File: rtl/mem_lsu_if.sv
// Bundles the LSU request/response handshake and the data-memory port.
// slave is the LSU side; master is the core plus memory side.
interface mem_lsu_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-3:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_lsu.sv
// Byte/half/word load-store unit in front of a word-organised memory; sub-word stores use RMW.
// Define LSU_MISALIGN_EXC_EN to flag misaligned half/word accesses via rsp_err instead of masking.
module mem_lsu #(
    parameter int unsigned ADDR_W = 8
) (
    input logic      clk,
    input logic      reset,
    mem_lsu_if.slave bus
);
    typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lo_q, lo_d;
    logic [ADDR_W-3:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              misalign;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;

`ifdef LSU_MISALIGN_EXC_EN
    // Size 11 decodes as word, so req_size[1] alone selects the word check.
    assign misalign = bus.req_size[1] ? (bus.req_addr[1:0] != 2'b00)
                                      : (bus.req_size[0] & bus.req_addr[0]);
`else
    assign misalign = 1'b0;
`endif

    assign byte_sel = bus.mem_rdata[{lo_q, 3'b000} +: 8];
    assign half_sel = lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    always_comb begin
        load_val = bus.mem_rdata;
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{16{~uns_q & half_sel[15]}}, half_sel};
            default: load_val = bus.mem_rdata;
        endcase
    end

    // wdata_q carries the raw store data until the RMW read folds it into the memory word.
    always_comb begin
        merge_val = bus.mem_rdata;
        if (size_q == 2'b00) begin
            merge_val[{lo_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_val[{lo_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        uns_d   = uns_q;
        lo_d    = lo_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    lo_d    = bus.req_addr[1:0];
                    waddr_d = bus.req_addr[ADDR_W-1:2];
                    wdata_d = bus.req_wdata;
                    if (misalign) begin
                        rdata_d = 32'h0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else if (!bus.req_we) begin
                        state_d = StLoad;
                    end else if (bus.req_size[1]) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRmwRd;
                    end
                end
            end
            StLoad: begin
                rdata_d = load_val;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StRmwRd: begin
                wdata_d = merge_val;
                state_d = StWrite;
            end
            StWrite: begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
                state_d = StResp;
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            lo_q    <= 2'b00;
            waddr_q <= '0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            lo_q    <= lo_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StResp);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.mem_addr  = waddr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_we    = (state_q == StWrite);
endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: behavioural word memory, response scoreboard, timing checks.
module tb_mem_lsu;
    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;
    int   we_cnt = 0;
    logic [5:0]  we_addr = '0;
    logic [31:0] we_data = '0;
    logic [31:0] mem [64] = '{5: 32'h8899AABB, default: 32'h0};
    exp_t exp_q [$];

    mem_lsu_if #(.ADDR_W(8)) bus ();

    mem_lsu #(.ADDR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            we_cnt  = we_cnt + 1;
            we_addr = bus.mem_addr;
            we_data = bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Scoreboard: each response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'(bus.rsp_valid), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("rsp_rdata", bus.rsp_rdata, e.rdata);
                check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
        end
    end

    // edges counts posedges from the accept edge (inclusive) until rsp_valid is seen.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic uns, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int edges);
        int   n;
        exp_t e;
        @(negedge clk);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept"}, 32'(bus.req_ready), 32'h1);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n = 1;
        while (!bus.rsp_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(edges));
        check({tag, "_busy"}, 32'(bus.req_ready), 32'h0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(bus.rsp_valid), 32'h0);
    endtask

    initial begin
        int w0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'h1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rdata", bus.rsp_rdata, 32'h0);
        check("rst_err", 32'(bus.rsp_err), 32'h0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
        check("rst_mem_wdata", bus.mem_wdata, 32'h0);
        check("rst_mem_we", 32'(bus.mem_we), 32'h0);

        w0 = we_cnt;
        do_req("lb", 1'b0, 2'b00, 1'b0, 8'h15, 32'h0, 32'hFFFFFFAA, 1'b0, 2);
        do_req("lbu", 1'b0, 2'b00, 1'b1, 8'h15, 32'h0, 32'h000000AA, 1'b0, 2);
        do_req("lhu", 1'b0, 2'b01, 1'b1, 8'h16, 32'h0, 32'h00008899, 1'b0, 2);
        do_req("lh", 1'b0, 2'b01, 1'b0, 8'h16, 32'h0, 32'hFFFF8899, 1'b0, 2);
        check("load_no_write", 32'(we_cnt - w0), 32'h0);

        // sb aborted by reset while in WRITE
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 8'h15;
        bus.req_wdata = 32'h00000077;
        check("abort_accept", 32'(bus.req_ready), 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("abort_we_high", 32'(bus.mem_we), 32'h1);
        reset = 1'b1;
        #1;
        check("abort_we_drop", 32'(bus.mem_we), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("abort_word5", mem[5], 32'h8899AABB);
        check("abort_ready", 32'(bus.req_ready), 32'h1);
        check("abort_no_write", 32'(we_cnt - w0), 32'h0);

        w0 = we_cnt;
        do_req("sh", 1'b1, 2'b01, 1'b0, 8'h16, 32'h00001234, 32'h0, 1'b0, 3);
        check("sh_we_cnt", 32'(we_cnt - w0), 32'h1);
        check("sh_we_addr", 32'(we_addr), 32'h5);
        check("sh_we_data", we_data, 32'h1234AABB);
        do_req("lw", 1'b0, 2'b10, 1'b0, 8'h14, 32'h0, 32'h1234AABB, 1'b0, 2);

        w0 = we_cnt;
        do_req("sw", 1'b1, 2'b10, 1'b0, 8'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2);
        check("sw_we_cnt", 32'(we_cnt - w0), 32'h1);
        check("sw_we_addr", 32'(we_addr), 32'h8);
        check("sw_we_data", we_data, 32'hDEADBEEF);

        w0 = we_cnt;
`ifdef LSU_MISALIGN_EXC_EN
        do_req("lw_mis", 1'b0, 2'b10, 1'b0, 8'h15, 32'h0, 32'h0, 1'b1, 1);
        do_req("sw_mis", 1'b1, 2'b11, 1'b0, 8'h22, 32'h55555555, 32'h0, 1'b1, 1);
        check("mis_no_write", 32'(we_cnt - w0), 32'h0);
`else
        do_req("lw_mis", 1'b0, 2'b10, 1'b0, 8'h15, 32'h0, 32'h1234AABB, 1'b0, 2);
        check("mis_no_write", 32'(we_cnt - w0), 32'h0);
`endif

        // Fill word 9 byte by byte; upper wdata bits must be ignored.
        for (int k = 0; k < 4; k++) begin
            do_req("sb_lane", 1'b1, 2'b00, 1'b0, 8'(8'h24 + k), 32'hABCDEF00 | 32'(8'h80 + k),
                   32'h0, 1'b0, 3);
        end
        do_req("lw9", 1'b0, 2'b10, 1'b0, 8'h24, 32'h0, 32'h83828180, 1'b0, 2);
        do_req("lb9", 1'b0, 2'b00, 1'b0, 8'h27, 32'h0, 32'hFFFFFF83, 1'b0, 2);
        do_req("lbu9", 1'b0, 2'b00, 1'b1, 8'h26, 32'h0, 32'h00000082, 1'b0, 2);
        do_req("lh9", 1'b0, 2'b01, 1'b0, 8'h26, 32'h0, 32'hFFFF8382, 1'b0, 2);
        do_req("lw_sz3", 1'b0, 2'b11, 1'b0, 8'h20, 32'h0, 32'hDEADBEEF, 1'b0, 2);

        repeat (2) @(negedge clk);
        check("sb_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end
endmodule
